// File: rtl/fpu_result_writeback.sv
// fpu_result_writeback
//   Buffers 64-bit FPU results with their destination word address in a small
//   FIFO and drains them into the result memory over a req/ack write port.
//   Also keeps sticky IEEE-754 class flags (NaN/Inf/Zero) and a wrapping count
//   of committed writes.
//
// Ports
//   clk_i          system clock, all state on posedge
//   rst_ni         synchronous active-low reset
//   in_valid_i     result present on in_result_i / in_addr_i
//   in_ready_o     FIFO has a free slot (registered state only)
//   in_result_i    IEEE-754 double from the fpu
//   in_addr_i      destination word address
//   wr_req_o       write request to result memory
//   wr_ack_i       memory took the write (pulse or level)
//   wr_addr_o      write address, stable while wr_req_o=1
//   wr_data_o      write data, stable while wr_req_o=1
//   flag_clr_i     clear sticky flags
//   flag_nan_o     sticky: NaN accepted
//   flag_inf_o     sticky: infinity accepted
//   flag_zero_o    sticky: +/-0 accepted
//   fifo_count_o   FIFO occupancy
//   wr_count_o     committed writes, wraps modulo 2^CW
//   busy_o         FIFO non-empty or write in flight
module fpu_result_writeback #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 13,
    parameter int unsigned CW    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [63:0]              in_result_i,
    input  logic [AW-1:0]            in_addr_i,
    output logic                     wr_req_o,
    input  logic                     wr_ack_i,
    output logic [AW-1:0]            wr_addr_o,
    output logic [63:0]              wr_data_o,
    input  logic                     flag_clr_i,
    output logic                     flag_nan_o,
    output logic                     flag_inf_o,
    output logic                     flag_zero_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic [CW-1:0]            wr_count_o,
    output logic                     busy_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e             state_q, state_d;
    logic [PtrW-1:0]    wptr_q, wptr_d;
    logic [PtrW-1:0]    rptr_q, rptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic               wr_req_q, wr_req_d;
    logic [AW-1:0]      wr_addr_q, wr_addr_d;
    logic [63:0]        wr_data_q, wr_data_d;
    logic               nan_q, nan_d;
    logic               inf_q, inf_d;
    logic               zero_q, zero_d;
    logic [CW-1:0]      wcnt_q, wcnt_d;

    logic [63:0]        data_mem [DEPTH];
    logic [AW-1:0]      addr_mem [DEPTH];

    logic               push;
    logic               pop;
    logic [PtrW-1:0]    rptr_nxt;
    logic [10:0]        in_exp;
    logic [51:0]        in_frac;
    logic               is_nan;
    logic               is_inf;
    logic               is_zero;

    // Readiness depends only on registered occupancy, never on wr_ack_i.
    assign in_ready_o = (count_q != CntW'(DEPTH));
    assign push       = in_valid_i && in_ready_o;
    assign rptr_nxt   = rptr_q + PtrW'(1);

    assign in_exp  = in_result_i[62:52];
    assign in_frac = in_result_i[51:0];
    assign is_nan  = (in_exp == 11'h7FF) && (in_frac != 52'd0);
    assign is_inf  = (in_exp == 11'h7FF) && (in_frac == 52'd0);
    assign is_zero = (in_exp == 11'h000) && (in_frac == 52'd0);

    // Write FSM: the head stays in the FIFO until acked, so the memory port
    // always shows a stable, already-stored entry.
    always_comb begin
        state_d   = state_q;
        wr_req_d  = wr_req_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    wr_addr_d = addr_mem[rptr_q];
                    wr_data_d = data_mem[rptr_q];
                    wr_req_d  = 1'b1;
                    state_d   = StReq;
                end
            end
            StReq: begin
                if (wr_ack_i) begin
                    pop = 1'b1;
                    if (count_q > CntW'(1)) begin
                        // Back-to-back: present the next entry immediately.
                        wr_addr_d = addr_mem[rptr_nxt];
                        wr_data_d = data_mem[rptr_nxt];
                    end else begin
                        wr_req_d = 1'b0;
                        state_d  = StIdle;
                    end
                end
            end
            default: begin
                state_d  = StIdle;
                wr_req_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d  = pop ? rptr_nxt : rptr_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        wcnt_d = pop ? wcnt_q + CW'(1) : wcnt_q;
        // A flagged push beats a simultaneous clear.
        nan_d  = (nan_q  && !flag_clr_i) || (push && is_nan);
        inf_d  = (inf_q  && !flag_clr_i) || (push && is_inf);
        zero_d = (zero_q && !flag_clr_i) || (push && is_zero);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            nan_q     <= 1'b0;
            inf_q     <= 1'b0;
            zero_q    <= 1'b0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            wr_req_q  <= wr_req_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            nan_q     <= nan_d;
            inf_q     <= inf_d;
            zero_q    <= zero_d;
            wcnt_q    <= wcnt_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push) begin
            data_mem[wptr_q] <= in_result_i;
            addr_mem[wptr_q] <= in_addr_i;
        end
    end

    assign wr_req_o     = wr_req_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign flag_nan_o   = nan_q;
    assign flag_inf_o   = inf_q;
    assign flag_zero_o  = zero_q;
    assign fifo_count_o = count_q;
    assign wr_count_o   = wcnt_q;
    assign busy_o       = (count_q != '0) || wr_req_q;

endmodule
